instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream fetch stage for the single-cycle datapath.
- Owns the fetch PC and issues requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small prefetch FIFO, and presents {instr, pc} to the decode/execute stage over valid/ready.
- Discards in-flight and buffered words on a branch/jump redirect.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset, asynchronous, active-high
- redirect_i  input  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  input  32  new fetch PC; bits [1:0] ignored (forced 0)
- mem_req_o  output  1  instruction memory request
- mem_addr_o  output  32  request address, word aligned
- mem_ack_i  input  1  memory returns mem_data_i this cycle
- mem_data_i  input  32  instruction word
- instr_valid_o  output  1  FIFO head holds a valid instruction
- instr_o  output  32  head instruction
- instr_pc_o  output  32  PC of head instruction
- instr_ready_i  input  1  consumer accepts head when valid && ready

Behaviour:
- Reset (async, active-high) sets:
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty
  - mem_req_o=0, mem_addr_o=RESET_PC
  - instr_valid_o=0, instr_o=0, instr_pc_o=0
- FSM states: IDLE, WAIT, DROP.
  - IDLE: if !redirect_i and FIFO count<DEPTH, go to WAIT; else stay.
  - WAIT: mem_req_o=1 and mem_addr_o=fetch_pc, held stable until ack. On mem_ack_i: push {fetch_pc, mem_data_i}, fetch_pc+=4, go to IDLE.
  - DROP: mem_req_o=1 with the original address, held until ack. On ack: data discarded, go to IDLE.
- Only one request is outstanding at a time. Ack may arrive on the first cycle req is high. mem_ack_i is ignored in IDLE.
- Outputs are registered from state: mem_req_o/mem_addr_o are driven from the state register, not combinationally from inputs.
- Latency: a pushed word appears on instr_valid_o the cycle after ack. Base throughput is 1 instruction per 2 cycles.
- Pop: on valid && ready, the head is removed. Push and pop in the same cycle are both performed, and count is unchanged.
- Full: no new request is issued when count==DEPTH. Because entry to WAIT requires space, an ack always has room, so overflow is impossible.
- Empty: instr_valid_o=0, and instr_o/instr_pc_o hold their last values (don't-care).
- Redirect (highest priority, any state):
  - FIFO flushed (count=0) and fetch_pc=redirect_pc_i&~3.
  - Any pop in the same cycle is ignored, and instr_valid_o=0 the next cycle.
  - From WAIT without ack: go to DROP. WAIT with ack in the same cycle: word dropped, go to IDLE.
  - DROP: stay in DROP with the new PC latched. If ack arrives in the same cycle, go to IDLE.
  - IDLE: stay in IDLE for one cycle, then fetch from the new PC.
- fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Reset asserted mid-request clears everything immediately. A late ack after reset is ignored because the state is IDLE.

Optional Feature:
- Macro IFU_STREAM_EN.
- When defined: an ack in WAIT stays in WAIT, presenting fetch_pc+4 on the next cycle, when space remains, i.e. (count + push − pop) < DEPTH. This gives 1 instruction/cycle with a zero-wait memory.
- When undefined: always return to IDLE after ack (2-cycle minimum per fetch).
- Redirect and DROP behaviour is identical in both builds.

Decomposition:
- Package ifu_pkg holds:
  - state enum {IDLE, WAIT, DROP}
  - PC_STEP=32'd4
  - INSTR_W=32, PC_W=32
  - fifo entry typedef struct {pc, instr}
- One sub-module: ifu_fifo, a synchronous FIFO of DEPTH 64-bit entries with push/pop/flush, count, full/empty, and an async active-high reset.

Test Plan:
- Reset release, ack 1 cycle after req, ready=1: requests at PCs 0,4,8. Consumer sees pc 0,4,8 with matching instr. Spacing is 2 cycles (1 with IFU_STREAM_EN).
- ready=0 and mem ack every cycle: exactly 4 pushes, then mem_req_o stays 0. Raise ready: pops in order, and refill resumes at pc 16.
- Redirect to 32'h100 while WAIT on pc 8, ack 3 cycles later: instr_valid_o drops the next cycle, the acked word is discarded, and the next request is 32'h100.
- Redirect to 32'h203 coincident with ack and pop: no push, no pop, FIFO empty, next mem_addr_o=32'h200.
- RESET_PC=32'hFFFF_FFF8: fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst_i mid-WAIT, then ack during reset: all outputs return to reset values, nothing is pushed, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package ifu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } ifu_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fifo_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return addr & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO of {pc, instr} entries with push/pop/flush and async active-high reset.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fifo_entry_t      wdata,
  output fifo_entry_t      rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush wins over both ports; overflow and underflow are dropped silently.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: single-outstanding req/ack to instruction memory feeding a prefetch FIFO.
// Define IFU_STREAM_EN to keep requesting back-to-back while the FIFO has room.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  ifu_state_e       state_q;
  ifu_state_e       state_d;
  logic [PC_W-1:0]  fetch_pc_q;
  logic [PC_W-1:0]  fetch_pc_d;
  logic [PC_W-1:0]  addr_q;
  logic [PC_W-1:0]  addr_d;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fifo_entry_t      push_entry;
  fifo_entry_t      head;

  assign push = (state_q == WAIT) && mem_ack_i && !redirect_i;
  assign pop  = !fifo_empty && instr_ready_i && !redirect_i;

`ifdef IFU_STREAM_EN
  logic [CNT_W:0] count_after;
  logic           space_after;
  assign count_after = {1'b0, fifo_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
  assign space_after = count_after < (CNT_W+1)'(DEPTH);
`else
  logic fifo_count_unused;
  assign fifo_count_unused = ^fifo_count;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
      case (state_q)
        WAIT, DROP: state_d = mem_ack_i ? IDLE : DROP;
        default:    state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: if (!fifo_full) state_d = WAIT;
        WAIT: begin
          if (mem_ack_i) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
`ifdef IFU_STREAM_EN
            state_d = space_after ? WAIT : IDLE;
`else
            state_d = IDLE;
`endif
          end
        end
        DROP:    if (mem_ack_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // A dropped request keeps its original address until the memory acks it.
    addr_d = (state_d == DROP) ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  assign mem_req_o  = (state_q != IDLE);
  assign mem_addr_o = addr_q;

  assign push_entry = '{pc: fetch_pc_q, instr: mem_data_i};

  ifu_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (push),
    .pop  (pop),
    .flush(redirect_i),
    .wdata(push_entry),
    .rdata(head),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: memory responder, in-order PC scoreboard, directed corners.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 4;
`ifdef IFU_STREAM_EN
  localparam int SPACING = 1;
`else
  localparam int SPACING = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RST_PC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // Reference model state: next PC the consumer must see, outstanding request, redirect tracking.
  logic [31:0] exp_pc;
  logic [31:0] req_addr;
  logic [31:0] arm_addr;
  logic [31:0] redir_target;
  logic [31:0] cond_addr;
  bit          req_pending;
  bit          prev_redir;
  bit          arm;
  int          lat;
  int          lat_max;
  int          lat_fixed;
  int          redir_mode;
  int          ready_pct;
  int          hits;
  int          acks;
  int          pops;
  int          cyc;
  int          pop_cyc[$];

  task automatic cycle();
    logic        ack;
    logic        rd;
    logic        rdy;
    logic [31:0] tgt;
    int          m;
    @(negedge clk);
    cyc++;
    if (prev_redir) chk("valid_after_redirect", 32'(instr_valid_o), 32'd0);
    ack = 1'b0;
    if (mem_req_o) begin
      if (!req_pending) begin
        req_pending = 1'b1;
        req_addr    = mem_addr_o;
        lat         = (lat_fixed >= 0) ? lat_fixed : $urandom_range(lat_max, 0);
        chk("req_aligned", mem_addr_o & 32'd3, 32'd0);
        if (arm) begin
          chk("first_req_after_restart", mem_addr_o, arm_addr);
          arm = 1'b0;
        end
      end else begin
        chk("addr_stable", mem_addr_o, req_addr);
      end
      ack = (lat == 0);
      if (lat > 0) lat--;
    end
    mem_ack_i  = ack;
    mem_data_i = ack ? memfn(mem_addr_o) : $urandom;
    if (ack) begin
      req_pending = 1'b0;
      acks++;
    end
    rdy = ($urandom_range(99, 0) < ready_pct);
    rd  = 1'b0;
    tgt = redir_target;
    m   = redir_mode;
    if (m == 1)      rd = mem_req_o && ack && instr_valid_o;
    else if (m == 2) rd = mem_req_o && !ack && (mem_addr_o == cond_addr);
    else if (m == 3) begin
      rd  = ($urandom_range(15, 0) == 0);
      tgt = $urandom;
    end else if (m == 4) rd = 1'b1;
    if (rd && m != 3) begin
      redir_mode = 0;
      hits++;
    end
    if (rd && m == 1) rdy = 1'b1;
    instr_ready_i = rdy;
    redirect_i    = rd;
    redirect_pc_i = rd ? tgt : $urandom;
    if (rd) begin
      exp_pc   = tgt & ~32'd3;
      arm      = 1'b1;
      arm_addr = tgt & ~32'd3;
    end else if (instr_valid_o && rdy) begin
      chk("pop_pc", instr_pc_o, exp_pc);
      chk("pop_instr", instr_o, memfn(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
      pop_cyc.push_back(cyc);
    end
    prev_redir = rd;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_hit(input string tag, input int budget);
    int h0;
    int n;
    h0 = hits;
    n  = 0;
    while (hits == h0 && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 32'(hits - h0), 32'd1);
    redir_mode = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(mem_req_o),     32'd0);
    chk({tag, "_addr"},  mem_addr_o,         RST_PC);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    chk({tag, "_instr"}, instr_o,            32'd0);
    chk({tag, "_pc"},    instr_pc_o,         32'd0);
  endtask

  task automatic model_restart();
    exp_pc      = RST_PC;
    req_pending = 1'b0;
    prev_redir  = 1'b0;
    arm         = 1'b1;
    arm_addr    = RST_PC;
    lat         = 0;
  endtask

  initial begin
    rst           = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    mem_ack_i     = 1'b0;
    mem_data_i    = '0;
    instr_ready_i = 1'b0;
    lat_max       = 0;
    lat_fixed     = 0;
    redir_mode    = 0;
    redir_target  = '0;
    cond_addr     = '0;
    ready_pct     = 100;
    hits          = 0;
    acks          = 0;
    pops          = 0;
    cyc           = 0;
    model_restart();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Zero-wait memory, consumer always ready: RESET_PC sequence wraps through zero.
    pop_cyc.delete();
    begin
      int n;
      n = 0;
      while (pop_cyc.size() < 3 && n < 40) begin
        cycle();
        n++;
      end
    end
    if (pop_cyc.size() >= 3) begin
      chk("spacing_a", 32'(pop_cyc[1] - pop_cyc[0]), 32'(SPACING));
      chk("spacing_b", 32'(pop_cyc[2] - pop_cyc[1]), 32'(SPACING));
    end else begin
      chk("first_pops_timeout", 32'(pop_cyc.size()), 32'd3);
    end
    run(6);

    // Consumer stalled: exactly DEPTH words fetched, then requests stop.
    ready_pct    = 0;
    redir_target = 32'h0;
    redir_mode   = 4;
    run_until_hit("redirect_zero", 2);
    acks = 0;
    run(20);
    chk("full_pushes", 32'(acks), 32'(DEPTH));
    chk("full_req_idle", 32'(mem_req_o), 32'd0);
    chk("full_valid", 32'(instr_valid_o), 32'd1);
    pops      = 0;
    ready_pct = 100;
    run(30);
    chk("refill_resumed", 32'(pops >= 6), 32'd1);

    // Redirect while the request for pc 8 is outstanding, ack 3 cycles later.
    redir_target = 32'h0;
    redir_mode   = 4;
    run_until_hit("redirect_zero_b", 2);
    lat_fixed    = 3;
    cond_addr    = 32'h8;
    redir_target = 32'h100;
    redir_mode   = 2;
    run_until_hit("redirect_in_wait", 80);
    pops = 0;
    run(40);
    chk("pops_after_wait_redirect", 32'(pops > 0), 32'd1);

    // Redirect coincident with ack and pop; unaligned target.
    lat_fixed    = 0;
    ready_pct    = 50;
    redir_target = 32'h203;
    redir_mode   = 1;
    run_until_hit("redirect_ack_pop", 80);
    cycle();
    chk("redir_ack_addr", mem_addr_o, 32'h200);
    chk("redir_ack_req", 32'(mem_req_o), 32'd0);
    run(30);

    // Reset asserted mid-request with a late ack arriving during reset.
    lat_fixed = 6;
    ready_pct = 0;
    begin
      int n;
      n = 0;
      while (!(mem_req_o && req_pending && lat > 0) && n < 40) begin
        cycle();
        n++;
      end
      chk("reset_wait_reached", 32'(mem_req_o && req_pending), 32'd1);
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    mem_ack_i  = 1'b1;
    mem_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack_i = 1'b0;
    chk("late_ack_valid", 32'(instr_valid_o), 32'd0);
    chk("late_ack_req", 32'(mem_req_o), 32'd0);
    rst = 1'b0;
    model_restart();
    lat_fixed = -1;
    lat_max   = 2;
    ready_pct = 70;
    pops      = 0;
    run(40);
    chk("pops_after_reset", 32'(pops > 0), 32'd1);

    // Random latency, random backpressure, random redirects.
    lat_max    = 3;
    ready_pct  = 60;
    redir_mode = 3;
    pops       = 0;
    run(1500);
    redir_mode = 0;
    chk("random_progress", 32'(pops > 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
